pipe_ctrl_unit: RTL and testbench

//  Pipelined successor of the single-cycle control decoder. Decodes the ID-stage instruction,

---
 rtl/pipe_ctrl_unit.sv | 189 ++++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: ID decode, ID/EX, EX/MEM and MEM/WB control registers,
// EX branch resolution, load-use interlock and saturating stall/flush counters.
module pipe_ctrl_unit #(
   parameter int INSTR_W   = 32,
   parameter int ALUOP_W   = 3,
   parameter int HAZARD_EN = 1,
   parameter int CNT_W     = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [INSTR_W-1:0] i_instr,
   input  logic               i_zero,
   input  logic               i_stall_in,
   output logic               o_if_stall,
   output logic               o_id_flush,
   output logic               o_pcsrc,
   output logic [1:0]         o_ex_imm_sel,
   output logic               o_ex_alusrc,
   output logic [ALUOP_W-1:0] o_ex_aluop,
   output logic               o_mem_memrw,
   output logic               o_wb_regrw,
   output logic               o_wb_sel,
   output logic [4:0]         o_wb_rd,
   output logic [CNT_W-1:0]   o_stall_cnt,
   output logic [CNT_W-1:0]   o_flush_cnt
);

   typedef struct packed {
      logic [1:0]         imm_sel;
      logic               alusrc;
      logic [ALUOP_W-1:0] aluop;
      logic               memrw;
      logic               wb_sel;
      logic               regrw;
      logic               branch;
      logic [4:0]         rd;
   } idex_t;

   typedef struct packed {
      logic       memrw;
      logic       wb_sel;
      logic       regrw;
      logic [4:0] rd;
   } exmem_t;

   typedef struct packed {
      logic       wb_sel;
      logic       regrw;
      logic [4:0] rd;
   } memwb_t;

   logic [3:0]  w_opc;
   logic [4:0]  w_rd;
   logic [4:0]  w_rs1;
   logic [4:0]  w_rs2;
   idex_t       w_dec;
   logic        w_valid;
   logic        w_rs2_use;
   logic        w_ex_load;
   logic        w_match;
   logic        w_taken;
   logic        w_hazard;
   logic        w_unused_bits;

   idex_t       r_ex;
   exmem_t      r_mem;
   memwb_t      r_wb;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   assign w_opc = {i_instr[13:12], i_instr[5:4]};
   assign w_rd  = i_instr[11:7];
   assign w_rs1 = i_instr[19:15];
   assign w_rs2 = i_instr[24:20];

   assign w_unused_bits = ^{i_instr[INSTR_W-1:25], i_instr[14],
                            i_instr[6], i_instr[3:0]};

   always_comb begin
      w_dec     = '0;
      w_valid   = 1'b1;
      w_rs2_use = 1'b0;
      unique case (w_opc)
         4'b0011: begin
            w_dec.wb_sel = 1'b1;
            w_dec.regrw  = 1'b1;
            w_rs2_use    = 1'b1;
         end
         4'b1011: begin
            w_dec.aluop  = ALUOP_W'(1);
            w_dec.wb_sel = 1'b1;
            w_dec.regrw  = 1'b1;
            w_rs2_use    = 1'b1;
         end
         4'b0111: begin
            w_dec.aluop  = ALUOP_W'(2);
            w_dec.wb_sel = 1'b1;
            w_dec.regrw  = 1'b1;
            w_rs2_use    = 1'b1;
         end
         4'b0001: begin
            w_dec.imm_sel = 2'b01;
            w_dec.alusrc  = 1'b1;
            w_dec.wb_sel  = 1'b1;
            w_dec.regrw   = 1'b1;
         end
         4'b1001: begin
            w_dec.imm_sel = 2'b01;
            w_dec.alusrc  = 1'b1;
            w_dec.aluop   = ALUOP_W'(1);
            w_dec.wb_sel  = 1'b1;
            w_dec.regrw   = 1'b1;
         end
         4'b0101: begin
            w_dec.imm_sel = 2'b01;
            w_dec.alusrc  = 1'b1;
            w_dec.aluop   = ALUOP_W'(2);
            w_dec.wb_sel  = 1'b1;
            w_dec.regrw   = 1'b1;
         end
         4'b1000: begin
            w_dec.imm_sel = 2'b01;
            w_dec.alusrc  = 1'b1;
            w_dec.regrw   = 1'b1;
         end
         4'b1010: begin
            w_dec.imm_sel = 2'b10;
            w_dec.alusrc  = 1'b1;
            w_dec.memrw   = 1'b1;
            w_rs2_use     = 1'b1;
         end
         4'b0010: begin
            w_dec.imm_sel = 2'b11;
            w_dec.aluop   = ALUOP_W'(3);
            w_dec.wb_sel  = 1'b1;
            w_dec.branch  = 1'b1;
            w_rs2_use     = 1'b1;
         end
         default: begin
            w_valid = 1'b0;
         end
      endcase
      w_dec.rd = w_valid ? w_rd : 5'd0;
   end

   assign w_taken   = r_ex.branch & i_zero & ~i_stall_in;
   assign w_ex_load = r_ex.regrw & ~r_ex.wb_sel & (r_ex.rd != 5'd0);
   assign w_match   = (w_valid & (w_rs1 == r_ex.rd)) |
                      (w_rs2_use & (w_rs2 == r_ex.rd));
   // A taken branch squashes the ID instruction, so its hazard is moot.
   assign w_hazard  = (HAZARD_EN != 0) & w_ex_load & w_match & ~w_taken;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ex        <= '0;
         r_mem       <= '0;
         r_wb        <= '0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else if (!i_stall_in) begin
         r_ex         <= (w_taken | w_hazard) ? '0 : w_dec;
         r_mem.memrw  <= r_ex.memrw;
         r_mem.wb_sel <= r_ex.wb_sel;
         r_mem.regrw  <= r_ex.regrw;
         r_mem.rd     <= r_ex.rd;
         r_wb.wb_sel  <= r_mem.wb_sel;
         r_wb.regrw   <= r_mem.regrw;
         r_wb.rd      <= r_mem.rd;
         if (w_hazard && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_taken && (r_flush_cnt != '1))
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign o_pcsrc      = w_taken;
   assign o_id_flush   = w_taken;
   assign o_if_stall   = w_hazard | i_stall_in;
   assign o_ex_imm_sel = r_ex.imm_sel;
   assign o_ex_alusrc  = r_ex.alusrc;
   assign o_ex_aluop   = r_ex.aluop;
   assign o_mem_memrw  = r_mem.memrw;
   assign o_wb_regrw   = r_wb.regrw;
   assign o_wb_sel     = r_wb.wb_sel;
   assign o_wb_rd      = r_wb.rd;
   assign o_stall_cnt  = r_stall_cnt;
   assign o_flush_cnt  = r_flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: an instruction-level reference model feeds a scoreboard
// queue; a monitor pops one expected snapshot per cycle and compares every output.
module tb_pipe_ctrl_unit;
   localparam int IW = 32;
   localparam int AW = 3;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [IW-1:0] instr = '0;
   logic          zero = 1'b0;
   logic          stall_in = 1'b0;
   logic          if_stall, id_flush, pcsrc, ex_alusrc;
   logic [1:0]    ex_imm_sel;
   logic [AW-1:0] ex_aluop;
   logic          mem_memrw, wb_regrw, wb_sel;
   logic [4:0]    wb_rd;
   logic [CW-1:0] stall_cnt, flush_cnt;

   pipe_ctrl_unit #(.INSTR_W(IW), .ALUOP_W(AW), .HAZARD_EN(1), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .i_instr(instr), .i_zero(zero),
      .i_stall_in(stall_in), .o_if_stall(if_stall), .o_id_flush(id_flush),
      .o_pcsrc(pcsrc), .o_ex_imm_sel(ex_imm_sel), .o_ex_alusrc(ex_alusrc),
      .o_ex_aluop(ex_aluop), .o_mem_memrw(mem_memrw), .o_wb_regrw(wb_regrw),
      .o_wb_sel(wb_sel), .o_wb_rd(wb_rd), .o_stall_cnt(stall_cnt),
      .o_flush_cnt(flush_cnt));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] imm;
      logic       alusrc;
      logic [2:0] aluop;
      logic       memrw, wbsel, regrw, branch;
      logic [4:0] rd;
   } ctl_t;

   typedef struct packed {
      logic       ifs, flush, pcsrc;
      logic [1:0] imm;
      logic       alusrc;
      logic [2:0] aluop;
      logic       memrw, regrw, wbsel;
      logic [4:0] rd;
      logic [CW-1:0] sc, fc;
   } exp_t;

   exp_t q[$];
   ctl_t m_ex, m_mem, m_wb;
   int   m_sc, m_fc;
   int   checks = 0;
   int   errors = 0;
   event ev;

   function automatic logic [3:0] opc(logic [31:0] ins);
      return {ins[13:12], ins[5:4]};
   endfunction

   // Spec decode table: {imm_sel, alusrc, aluop, memrw, wb_sel, regrw, branch}
   function automatic ctl_t dec(logic [31:0] ins);
      logic [9:0] t;
      ctl_t c;
      case (opc(ins))
         4'b0011: t = 10'b00_0_000_0_1_1_0;
         4'b1011: t = 10'b00_0_001_0_1_1_0;
         4'b0111: t = 10'b00_0_010_0_1_1_0;
         4'b0001: t = 10'b01_1_000_0_1_1_0;
         4'b1001: t = 10'b01_1_001_0_1_1_0;
         4'b0101: t = 10'b01_1_010_0_1_1_0;
         4'b1000: t = 10'b01_1_000_0_0_1_0;
         4'b1010: t = 10'b10_1_000_1_0_0_0;
         4'b0010: t = 10'b11_0_011_0_1_0_1;
         default: t = 10'b0;
      endcase
      c = {t, 5'd0};
      if (is_op(ins)) c.rd = ins[11:7];
      return c;
   endfunction

   function automatic bit is_op(logic [31:0] ins);
      return opc(ins) inside {4'b0011, 4'b1011, 4'b0111, 4'b0001, 4'b1001,
                              4'b0101, 4'b1000, 4'b1010, 4'b0010};
   endfunction

   function automatic bit rs2_used(logic [31:0] ins);
      return opc(ins) inside {4'b0011, 4'b1011, 4'b0111, 4'b1010, 4'b0010};
   endfunction

   function automatic logic [31:0] mk(logic [3:0] op, logic [4:0] rd,
                                      logic [4:0] rs1, logic [4:0] rs2);
      logic [31:0] r;
      r = $urandom;
      r[13:12] = op[3:2];
      r[5:4]   = op[1:0];
      r[11:7]  = rd;
      r[19:15] = rs1;
      r[24:20] = rs2;
      return r;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(ev);
         #1;
         while (q.size() > 0) begin
            e = q.pop_front();
            chk("if_stall", if_stall, e.ifs);
            chk("id_flush", id_flush, e.flush);
            chk("pcsrc", pcsrc, e.pcsrc);
            chk("ex_imm_sel", ex_imm_sel, e.imm);
            chk("ex_alusrc", ex_alusrc, e.alusrc);
            chk("ex_aluop", ex_aluop, e.aluop);
            chk("mem_memrw", mem_memrw, e.memrw);
            chk("wb_regrw", wb_regrw, e.regrw);
            chk("wb_sel", wb_sel, e.wbsel);
            chk("wb_rd", wb_rd, e.rd);
            chk("stall_cnt", stall_cnt, e.sc);
            chk("flush_cnt", flush_cnt, e.fc);
         end
      end
   end

   // One cycle: drive ID inputs, predict outputs, then advance the model.
   task automatic step(input logic [31:0] ins, input logic z, input logic st,
                       output exp_t e);
      ctl_t d;
      bit   taken, haz, hz;
      @(negedge clk);
      instr = ins;
      zero = z;
      stall_in = st;
      #1;
      d = dec(ins);
      taken = m_ex.branch && z && !st;
      haz = m_ex.regrw && !m_ex.wbsel && m_ex.rd != 0 &&
            ((is_op(ins) && ins[19:15] == m_ex.rd) ||
             (rs2_used(ins) && ins[24:20] == m_ex.rd));
      hz = haz && !taken;
      e.ifs = hz || st;
      e.flush = taken;
      e.pcsrc = taken;
      e.imm = m_ex.imm;
      e.alusrc = m_ex.alusrc;
      e.aluop = m_ex.aluop;
      e.memrw = m_mem.memrw;
      e.regrw = m_wb.regrw;
      e.wbsel = m_wb.wbsel;
      e.rd = m_wb.rd;
      e.sc = CW'(m_sc);
      e.fc = CW'(m_fc);
      q.push_back(e);
      ->ev;
      if (!st) begin
         m_wb = m_mem;
         m_mem = m_ex;
         m_ex = (taken || hz) ? ctl_t'(0) : d;
         if (hz && m_sc < 2**CW - 1) m_sc++;
         if (taken && m_fc < 2**CW - 1) m_fc++;
      end
   endtask

   // Acts as the fetch stage: holds ID on if_stall, inserts a bubble on flush.
   task automatic run(input logic [31:0] prog[$], input int zmode,
                      input int stpct, input int extra);
      logic [31:0] ins;
      exp_t e;
      logic z, st;
      int cnt;
      cnt = prog.size() * 3 + extra;
      ins = '0;
      if (prog.size() > 0) ins = prog.pop_front();
      for (int n = 0; n < cnt; n++) begin
         z = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
         st = ($urandom_range(0, 99) < stpct);
         step(ins, z, st, e);
         if (!e.ifs) begin
            if (e.flush) ins = '0;
            else if (prog.size() > 0) ins = prog.pop_front();
            else ins = '0;
         end
      end
   endtask

   task automatic chk_zero_outs(string tag);
      chk({tag, "_ifs"}, if_stall, 0);
      chk({tag, "_flush"}, id_flush, 0);
      chk({tag, "_pcsrc"}, pcsrc, 0);
      chk({tag, "_ex"}, {ex_imm_sel, ex_alusrc, ex_aluop}, 0);
      chk({tag, "_mem"}, mem_memrw, 0);
      chk({tag, "_wb"}, {wb_regrw, wb_sel, wb_rd}, 0);
      chk({tag, "_cnt"}, {stall_cnt, flush_cnt}, 0);
   endtask

   task automatic model_reset();
      m_ex = '0;
      m_mem = '0;
      m_wb = '0;
      m_sc = 0;
      m_fc = 0;
   endtask

   initial begin : stim
      logic [31:0] p[$];
      exp_t e;
      logic [3:0] ops[10];
      logic [3:0] op;
      ops = '{4'b0011, 4'b1011, 4'b0111, 4'b0001, 4'b1001,
              4'b0101, 4'b1000, 4'b1010, 4'b0010, 4'b1111};
      model_reset();
      repeat (2) @(negedge clk);
      #2;
      chk_zero_outs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // add, addi, store: aluop and store's single memrw pulse
      p = '{mk(4'b0011, 1, 2, 3), mk(4'b0001, 4, 2, 0), mk(4'b1010, 0, 1, 4)};
      run(p, 0, 0, 2);
      // load x5 -> add x5: one bubble; load x0 -> no stall
      p = '{mk(4'b1000, 5, 1, 0), mk(4'b0011, 6, 5, 2)};
      run(p, 0, 0, 2);
      p = '{mk(4'b1000, 0, 1, 0), mk(4'b0011, 6, 0, 0)};
      run(p, 0, 0, 2);
      // load then store using rs2 of the loaded reg
      p = '{mk(4'b1000, 7, 1, 0), mk(4'b1010, 0, 2, 7)};
      run(p, 0, 0, 2);
      // branch taken, then not taken
      p = '{mk(4'b0010, 0, 1, 2), mk(4'b0011, 3, 1, 2), mk(4'b0001, 4, 1, 0)};
      run(p, 1, 0, 2);
      p = '{mk(4'b0010, 0, 1, 2), mk(4'b0011, 3, 1, 2), mk(4'b0001, 4, 1, 0)};
      run(p, 0, 0, 2);
      // load feeding a branch, with zero high throughout
      p = '{mk(4'b1000, 9, 1, 0), mk(4'b0010, 0, 9, 9), mk(4'b0011, 3, 9, 1)};
      run(p, 1, 0, 3);
      // external freeze mixed with traffic
      p = '{mk(4'b1000, 5, 1, 0), mk(4'b0011, 6, 5, 2), mk(4'b0010, 0, 1, 2),
            mk(4'b1010, 0, 1, 2), mk(4'b0001, 8, 1, 0)};
      run(p, 1, 50, 6);
      // saturation: 19 load-use pairs on a 4-bit counter
      p.delete();
      for (int i = 0; i < 19; i++) begin
         p.push_back(mk(4'b1000, 5, 1, 0));
         p.push_back(mk(4'b0011, 6, 5, 5));
      end
      run(p, 0, 0, 2);
      @(negedge clk);
      #2;
      chk("stall_sat", stall_cnt, 4'hF);
      // randomized traffic
      p.delete();
      for (int i = 0; i < 300; i++) begin
         op = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 8)]
                                         : 4'($urandom_range(0, 15));
         p.push_back(mk(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                        5'($urandom_range(0, 3))));
      end
      run(p, 2, 15, 4);
      // reset with control in flight
      step(mk(4'b1000, 5, 1, 0), 1'b0, 1'b0, e);
      step(mk(4'b1010, 0, 2, 3), 1'b0, 1'b0, e);
      step(mk(4'b0011, 6, 1, 2), 1'b0, 1'b0, e);
      @(negedge clk);
      #3;
      rst_n = 1'b0;
      instr = '0;
      stall_in = 1'b0;
      #1;
      chk_zero_outs("midrst");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      p = '{mk(4'b0101, 2, 1, 0), mk(4'b0010, 0, 2, 1), mk(4'b0011, 3, 1, 2)};
      run(p, 1, 0, 3);
      #20;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
